// File: rtl/regfile_writeback_arbiter_pkg.sv
// rtl/regfile_writeback_arbiter_pkg.sv - shared constants and types for the writeback arbiter
package regfile_writeback_arbiter_pkg;

    localparam int NUM_REGISTERS = 32;
    localparam int WB_XLEN       = 64;
    localparam int WB_ADDR_SIZE  = 5;

    typedef enum logic [1:0] {
        SRC_ALU    = 2'd0,
        SRC_LOAD   = 2'd1,
        SRC_MULDIV = 2'd2
    } src_idx_e;

    typedef struct packed {
        logic                    valid;
        logic [WB_ADDR_SIZE-1:0] addr;
        logic [WB_XLEN-1:0]      data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_arbiter_rr_arbiter.sv
// rtl/regfile_writeback_arbiter_rr_arbiter.sv - round-robin one-hot arbiter with last-grant state
module rr_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic               advance,
    output logic [NUM_SRC-1:0] gnt,
    output logic [IDX_W-1:0]   last_grant
);

    logic [IDX_W-1:0] last_grant_q;
    logic [IDX_W-1:0] last_grant_d;

    // Search requesters starting one past the previous winner; first hit wins.
    always_comb begin
        int idx;
        logic found;
        gnt          = '0;
        last_grant_d = last_grant_q;
        found        = 1'b0;
        idx          = 0;
        for (int off = 1; off <= NUM_SRC; off++) begin
            idx = (int'(last_grant_q) + off) % NUM_SRC;
            if (!found && req[idx[IDX_W-1:0]]) begin
                gnt[idx[IDX_W-1:0]] = 1'b1;
                last_grant_d        = idx[IDX_W-1:0];
                found               = 1'b1;
            end
        end
    end

    // Pointer moves only when a grant is actually issued; reset makes source 0 first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= IDX_W'(NUM_SRC - 1);
        end else if (advance) begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// rtl/regfile_writeback_arbiter.sv - per-source holding buffers arbitrated onto one regfile write port; WB_STALL_CNT_EN adds stall_cnt
module regfile_writeback_arbiter
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int ADDR_SIZE = 5,
    parameter int NUM_SRC   = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC-1:0]          src_valid,
    output logic [NUM_SRC-1:0]          src_ready,
    input  logic [NUM_SRC*ADDR_SIZE-1:0] src_addr,
    input  logic [NUM_SRC*XLEN-1:0]     src_data,
    output logic                        write_enable,
    output logic [ADDR_SIZE-1:0]        write_addr,
    output logic signed [XLEN-1:0]      write_data,
    output logic [NUM_REGISTERS-1:0]    pending_mask
`ifdef WB_STALL_CNT_EN
    ,
    output logic [15:0]                 stall_cnt
`endif
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]   buf_valid_q, buf_valid_d;
    logic [ADDR_SIZE-1:0] buf_addr_q [NUM_SRC];
    logic [ADDR_SIZE-1:0] buf_addr_d [NUM_SRC];
    logic [XLEN-1:0]      buf_data_q [NUM_SRC];
    logic [XLEN-1:0]      buf_data_d [NUM_SRC];

    logic                 write_enable_q, write_enable_d;
    logic [ADDR_SIZE-1:0] write_addr_q, write_addr_d;
    logic [XLEN-1:0]      write_data_q, write_data_d;

    logic [NUM_SRC-1:0]   gnt;
    logic [NUM_SRC-1:0]   xfer;
    logic [IDX_W-1:0]     last_grant_unused;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .clk        (clk),
        .rst        (rst),
        .req        (buf_valid_q),
        .advance    (|gnt),
        .gnt        (gnt),
        .last_grant (last_grant_unused)
    );

    // A buffer can accept when empty or when it drains this cycle; forced high during reset.
    assign src_ready = {NUM_SRC{rst}} | ~buf_valid_q | gnt;
    assign xfer      = src_valid & src_ready;

    // Buffer next state: drain on grant, reload on transfer; x0 results are swallowed.
    always_comb begin
        buf_valid_d = buf_valid_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            buf_addr_d[i] = buf_addr_q[i];
            buf_data_d[i] = buf_data_q[i];
            if (gnt[i]) begin
                buf_valid_d[i] = 1'b0;
            end
            if (xfer[i] && (src_addr[i*ADDR_SIZE +: ADDR_SIZE] != '0)) begin
                buf_valid_d[i] = 1'b1;
                buf_addr_d[i]  = src_addr[i*ADDR_SIZE +: ADDR_SIZE];
                buf_data_d[i]  = src_data[i*XLEN +: XLEN];
            end
        end
    end

    // Write port next state: the granted buffer is copied out, otherwise addr/data hold.
    always_comb begin
        write_enable_d = |gnt;
        write_addr_d   = write_addr_q;
        write_data_d   = write_data_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt[i]) begin
                write_addr_d = buf_addr_q[i];
                write_data_d = buf_data_q[i];
            end
        end
    end

    // Control state with reset: buffered results are dropped, write port zeroed.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q    <= '0;
            write_enable_q <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
        end else begin
            buf_valid_q    <= buf_valid_d;
            write_enable_q <= write_enable_d;
            write_addr_q   <= write_addr_d;
            write_data_q   <= write_data_d;
        end
    end

    // Buffer payload needs no reset; it is only observed while its valid bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            buf_addr_q[i] <= buf_addr_d[i];
            buf_data_q[i] <= buf_data_d[i];
        end
    end

    // Scoreboard view: registers with a write still buffered or on the port this cycle.
    always_comb begin
        pending_mask = '0;
        for (int k = 1; k < NUM_REGISTERS; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (buf_valid_q[i] && (buf_addr_q[i] == ADDR_SIZE'(k))) begin
                    pending_mask[k] = 1'b1;
                end
            end
            if (write_enable_q && (write_addr_q == ADDR_SIZE'(k))) begin
                pending_mask[k] = 1'b1;
            end
        end
    end

    assign write_enable = write_enable_q;
    assign write_addr   = write_addr_q;
    assign write_data   = write_data_q;

`ifdef WB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Count cycles where some source offers a result that cannot be taken; saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if ((|(src_valid & ~src_ready)) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb/tb_regfile_writeback_arbiter.sv - self-checking bench for regfile_writeback_arbiter
module tb_regfile_writeback_arbiter;

    localparam int XLEN = 64;
    localparam int AS   = 5;
    localparam int NS   = 3;

    logic              clk;
    logic              rst;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic [NS*AS-1:0]  src_addr;
    logic [NS*XLEN-1:0] src_data;
    logic              write_enable;
    logic [AS-1:0]     write_addr;
    logic signed [XLEN-1:0] write_data;
    logic [31:0]       pending_mask;
`ifdef WB_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    regfile_writeback_arbiter #(
        .XLEN      (XLEN),
        .ADDR_SIZE (AS),
        .NUM_SRC   (NS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .src_addr     (src_addr),
        .src_data     (src_data),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .pending_mask (pending_mask)
`ifdef WB_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit sb_off  = 1'b0;

    typedef struct {
        int          src;
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        int          src;
        logic [4:0]  addr;
        logic [63:0] data;
        logic        exp_we;
        logic [31:0] exp_mask;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic [4:0] a, input logic [63:0] d);
        wr_t e;
        src_valid[s]          = 1'b1;
        src_addr[s*AS +: AS]  = a;
        src_data[s*XLEN +: XLEN] = d;
        if (src_ready[s] && a != 5'd0) begin
            e.src  = s;
            e.addr = a;
            e.data = d;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        src_valid = '0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        src_valid = '0;
        tick();
        check("rst_ready_during", {61'd0, src_ready}, 64'h7);
        rst = 1'b0;
        sb.delete();
        check("rst_we", {63'd0, write_enable}, 64'd0);
        check("rst_waddr", {59'd0, write_addr}, 64'd0);
        check("rst_wdata", write_data, 64'd0);
        check("rst_mask", {32'd0, pending_mask}, 64'd0);
        check("rst_ready_after", {61'd0, src_ready}, 64'h7);
    endtask

    // Scoreboard monitor: every write must match an outstanding transfer, in per-source order.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (write_enable === 1'b1 && !sb_off) begin
                int hit;
                int first;
                hit = -1;
                for (int j = 0; j < sb.size(); j++) begin
                    if (hit < 0 && sb[j].addr == write_addr && sb[j].data == write_data) hit = j;
                end
                if (hit < 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_match: write addr %0d data %0h matches no expected write", write_addr, write_data);
                end else begin
                    first = -1;
                    for (int j = 0; j < sb.size(); j++) begin
                        if (first < 0 && sb[j].src == sb[hit].src) first = j;
                    end
                    check("sb_order", 64'(first), 64'(hit));
                    sb.delete(hit);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        src_valid = '0;
        src_addr  = '0;
        src_data  = '0;
        tick();
        do_reset();

        vecs[0] = '{0, 5'd5,  64'h1234,                1'b1, 32'h0000_0020};
        vecs[1] = '{1, 5'd0,  64'hDEAD,                1'b0, 32'h0000_0000};
        vecs[2] = '{2, 5'd31, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 32'h8000_0000};
        vecs[3] = '{1, 5'd9,  64'h8000_0000_0000_0000, 1'b1, 32'h0000_0200};
        vecs[4] = '{2, 5'd1,  64'h0,                   1'b1, 32'h0000_0002};
        vecs[5] = '{0, 5'd0,  64'h55,                  1'b0, 32'h0000_0000};

        // Single uncontended transfers: latency, pending window and x0 discard.
        for (int v = 0; v < 6; v++) begin
            drive(vecs[v].src, vecs[v].addr, vecs[v].data);
            check("vec_ready", {63'd0, src_ready[vecs[v].src]}, 64'd1);
            tick();
            idle();
            check("vec_we_e0", {63'd0, write_enable}, 64'd0);
            check("vec_mask_e0", {32'd0, pending_mask}, {32'd0, vecs[v].exp_mask});
            tick();
            check("vec_we_e1", {63'd0, write_enable}, {63'd0, vecs[v].exp_we});
            check("vec_mask_e1", {32'd0, pending_mask}, {32'd0, vecs[v].exp_mask});
            if (vecs[v].exp_we) begin
                check("vec_waddr", {59'd0, write_addr}, {59'd0, vecs[v].addr});
                check("vec_wdata", write_data, vecs[v].data);
            end
            tick();
            check("vec_we_e2", {63'd0, write_enable}, 64'd0);
            check("vec_mask_e2", {32'd0, pending_mask}, 64'd0);
        end

        // Three-way contention from reset: source 0 first, then 1, then 2.
        do_reset();
        drive(0, 5'd1, 64'hA1);
        drive(1, 5'd2, 64'hA2);
        drive(2, 5'd3, 64'hA3);
        check("c3_ready_in", {61'd0, src_ready}, 64'h7);
        tick();
        idle();
        check("c3_ready_e0", {61'd0, src_ready}, 64'h1);
        check("c3_mask_e0", {32'd0, pending_mask}, 64'hE);
        tick();
        check("c3_we_e1", {63'd0, write_enable}, 64'd1);
        check("c3_addr_e1", {59'd0, write_addr}, 64'd1);
        check("c3_ready_e1", {61'd0, src_ready}, 64'h3);
        check("c3_mask_e1", {32'd0, pending_mask}, 64'hE);
        tick();
        check("c3_addr_e2", {59'd0, write_addr}, 64'd2);
        check("c3_mask_e2", {32'd0, pending_mask}, 64'hC);
        tick();
        check("c3_addr_e3", {59'd0, write_addr}, 64'd3);
        check("c3_we_e3", {63'd0, write_enable}, 64'd1);
        check("c3_mask_e3", {32'd0, pending_mask}, 64'h8);
        tick();
        check("c3_we_e4", {63'd0, write_enable}, 64'd0);

        // Source-0-only request moves the pointer; next full round starts at source 1.
        drive(0, 5'd4, 64'hB4);
        tick();
        idle();
        tick();
        check("s0_addr", {59'd0, write_addr}, 64'd4);
        tick();
        drive(0, 5'd10, 64'hC0);
        drive(1, 5'd11, 64'hC1);
        drive(2, 5'd12, 64'hC2);
        tick();
        idle();
        check("r2_ready_e0", {61'd0, src_ready}, 64'h2);
        tick();
        check("r2_addr_e1", {59'd0, write_addr}, 64'd11);
        tick();
        check("r2_addr_e2", {59'd0, write_addr}, 64'd12);
        tick();
        check("r2_addr_e3", {59'd0, write_addr}, 64'd10);
        tick();
        check("r2_we_e4", {63'd0, write_enable}, 64'd0);

        // Back-to-back stream on source 0: no backpressure, one write per cycle.
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                drive(0, 5'(i + 1), 64'h100 + 64'(i));
                check("b2b_ready", {63'd0, src_ready[0]}, 64'd1);
            end else begin
                idle();
            end
            tick();
            check("b2b_we", {63'd0, write_enable}, {63'd0, (i >= 1 && i <= 8)});
            if (i >= 1 && i <= 8) check("b2b_addr", {59'd0, write_addr}, 64'(i));
        end

        // Reset while source 2 holds a result: it must never be written.
        drive(2, 5'd7, 64'h77);
        tick();
        idle();
        check("rmf_mask_before", {32'd0, pending_mask}, 64'h80);
        rst = 1'b1;
        sb.delete();
        tick();
        check("rmf_ready_rst", {61'd0, src_ready}, 64'h7);
        check("rmf_we", {63'd0, write_enable}, 64'd0);
        check("rmf_waddr", {59'd0, write_addr}, 64'd0);
        check("rmf_wdata", write_data, 64'd0);
        check("rmf_mask", {32'd0, pending_mask}, 64'd0);
        rst = 1'b0;
        tick();
        check("rmf_we_after", {63'd0, write_enable}, 64'd0);
        check("rmf_mask_after", {32'd0, pending_mask}, 64'd0);
        tick();
        check("rmf_we_after2", {63'd0, write_enable}, 64'd0);

`ifdef WB_STALL_CNT_EN
        // All sources held valid: from the second edge on, two are blocked every cycle.
        do_reset();
        sb_off    = 1'b1;
        src_addr  = {5'd22, 5'd21, 5'd20};
        src_valid = 3'b111;
        for (int i = 0; i < 5; i++) tick();
        check("stall_4", {48'd0, stall_cnt}, 64'd4);
        for (int i = 0; i < 70000; i++) @(posedge clk);
        #1;
        check("stall_sat", {48'd0, stall_cnt}, 64'hFFFF);
        do_reset();
        sb_off = 1'b0;
`endif

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_writeback_arbiter.md
REGFILE_WRITEBACK_ARBITER -- requirements
Module: regfile_writeback_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- XLEN, 64, data width.
- ADDR_SIZE, 5, register address width.
- NUM_SRC, 3, number of result sources (0=ALU, 1=load, 2=mul/div).

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-high.
- src_valid, in, NUM_SRC, per-source result valid.
- src_ready, out, NUM_SRC, per-source accept.
- src_addr, in, NUM_SRC x ADDR_SIZE, destination register.
- src_data, in, NUM_SRC x XLEN, signed result.
- write_enable, out, 1, register-file write strobe.
- write_addr, out, ADDR_SIZE, register-file write address.
- write_data, out, XLEN, signed register-file write data.
- pending_mask, out, 32, destination registers with in-flight writes.

Function
REQ-003 Each source SHALL own a one-entry holding buffer (valid, addr, data).
REQ-004 A transfer SHALL occur on a rising edge where src_valid[i] and src_ready[i] are both high.
REQ-005 src_ready[i] SHALL be high when buffer i is empty or buffer i is granted in the current cycle (full-throughput reload).
REQ-006 A transfer with src_addr[i]==0 SHALL be accepted and discarded; it SHALL NOT load the buffer and SHALL never produce write_enable.
REQ-007 Each cycle, at most one valid buffer SHALL be granted, using round-robin starting at (last_grant+1) mod NUM_SRC.
REQ-008 last_grant SHALL update only on a grant.
REQ-009 On the edge following a grant:
- write_enable SHALL be 1.
- write_addr and write_data SHALL take the granted buffer's contents.
- The buffer SHALL clear, unless it reloads in that same edge per REQ-005.
REQ-010 With no grant, write_enable SHALL be 0 on the next edge; write_addr and write_data SHALL hold their values.
REQ-011 Latency: for a transfer at edge E0 with no contention, write_enable SHALL be high in the cycle after edge E1. Minimum latency is 2 edges.
REQ-012 Per-source ordering SHALL be preserved. No cross-source ordering is guaranteed; same-address conflicts across sources are the issuer's responsibility.
REQ-013 pending_mask SHALL be combinational. Bit k SHALL be set if any valid buffer holds addr k, or if write_enable is high with write_addr==k. Bit 0 SHALL always be 0.
REQ-014 Simultaneous requests from all sources SHALL be served within NUM_SRC consecutive cycles. No source SHALL starve.

Reset
REQ-015 On rst at a rising edge:
- All buffers SHALL clear.
- write_enable, write_addr and write_data SHALL be 0.
- last_grant SHALL be NUM_SRC-1, so source 0 wins first.
REQ-016 Reset mid-operation SHALL drop all buffered results without a write.
REQ-017 src_ready SHALL read as all-ones while rst is high and on the first cycle after reset.

Configuration
REQ-018 Macro WB_STALL_CNT_EN:
- Defined: add output stall_cnt, 16 bits. It SHALL reset to 0 and increment by 1 each cycle in which any src_valid[i] is high while src_ready[i] is low. It SHALL saturate at 16'hFFFF.
- Undefined: the port and its counter SHALL be absent.

Structure
REQ-019 A shared package SHALL hold:
- the NUM_REGISTERS=32 constant;
- the source-index enum (SRC_ALU, SRC_LOAD, SRC_MULDIV);
- a writeback-entry struct typedef (valid, addr, data).
REQ-020 The round-robin arbiter SHALL be a sub-module, rr_arbiter, with inputs req[NUM_SRC] and advance, and outputs one-hot gnt[NUM_SRC] plus the last_grant state.

Verification
REQ-021 Single ALU write: src0 addr 5, data 0x1234 at edge E0 -> write_enable=1, write_addr=5, write_data=0x1234 after E1; pending_mask[5] set from E0 until the write cycle ends.
REQ-022 Write to x0: src1 addr 0, data 0xDEAD -> src_ready stays 1, write_enable never asserts, pending_mask stays 0.
REQ-023 Three-way contention: all sources valid in one cycle with addrs 1, 2, 3 -> writes in order 1, 2, 3 on consecutive cycles; the next round after a source-0-only request starts at source 1.
REQ-024 Back-to-back stream: src0 valid for 8 cycles, addrs 1..8 -> src_ready stays 1 throughout and 8 consecutive writes occur in address order.
REQ-025 Reset mid-flight: src2 buffered with addr 7, then rst asserted -> no write to 7, pending_mask=0, and all outputs 0 on the next cycle.
REQ-026 With WB_STALL_CNT_EN: src1 held valid while blocked for 4 cycles -> stall_cnt=4; after 70000 blocked cycles -> stall_cnt=0xFFFF.
